// File: rtl/target_encoder.sv
// ---------------------------------------------------------------------------
// target_encoder
//
// Purpose:
//   Encodes a 16-bit branch target into a 4-bit table index. The block
//   compares the target with a 16-entry table, one entry per clock, starting
//   at entry 0. The lowest matching index wins. A search ends with a one-cycle
//   done pulse. hit and index then hold the result until the next completed
//   search.
//
// Configuration:
//   TGT_ENC_WRITE_EN  defined   : the table is held in registers. wr_en,
//                                 wr_addr and wr_data write it on any edge.
//                                 Reset restores the default contents.
//                     undefined : the table is the constant default contents.
//                                 The write port is ignored.
//
// Ports:
//   CLK        in   1   system clock; all state updates on the rising edge
//   Reset_n    in   1   asynchronous active-low reset
//   req        in   1   search request; sampled only in IDLE
//   req_target in  16   target value; captured when req is accepted
//   busy       out  1   high in SEARCH and DONE
//   done       out  1   registered one-cycle completion pulse
//   hit        out  1   the last completed search found the target
//   index      out  4   index of the match; 0 on a miss
//   wr_en      in   1   table write strobe (TGT_ENC_WRITE_EN only)
//   wr_addr    in   4   table write index
//   wr_data    in  16   table write value
// ---------------------------------------------------------------------------
module target_encoder (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        req,
  input  logic [15:0] req_target,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [3:0]  index,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [3:0]  ptr;
  logic [15:0] target;
  logic [15:0] entry;

  // Default table contents. Entries 13..15 are zero. Target 0 still returns
  // index 0, because the scan is ascending and stops on the first match.
  function automatic logic [15:0] default_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    default_entry = 16'd0;
      4'd1:    default_entry = 16'd1;
      4'd2:    default_entry = 16'd4;
      4'd3:    default_entry = 16'd61;
      4'd4:    default_entry = 16'd62;
      4'd5:    default_entry = 16'd63;
      4'd6:    default_entry = 16'd32;
      4'd7:    default_entry = 16'd64;
      4'd8:    default_entry = 16'd255;
      4'd9:    default_entry = 16'd51;
      4'd10:   default_entry = 16'd59;
      4'd11:   default_entry = 16'd41;
      4'd12:   default_entry = 16'd22;
      default: default_entry = 16'd0;
    endcase
  endfunction

`ifdef TGT_ENC_WRITE_EN
  logic [15:0] tbl [16];

  // NOTE: this table is reset element by element, so it becomes flops rather
  // than a RAM macro. That is intended: reset must restore the defaults.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) tbl[i] <= default_entry(4'(i));
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // The compare reads tbl before the edge. A write and a compare to the same
  // entry on the same edge therefore compare the old value.
  assign entry = tbl[ptr];
`else
  assign entry = default_entry(ptr);

  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // NOTE: all state below uses non-blocking assignments. Every register then
  // sees values from before the edge, and the result does not depend on the
  // order of the statements.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      ptr    <= 4'd0;
      target <= 16'd0;
      done   <= 1'b0;
      hit    <= 1'b0;
      index  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            target <= req_target;
            ptr    <= 4'd0;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (entry == target) begin
            hit   <= 1'b1;
            index <= ptr;
            done  <= 1'b1;
            state <= DONE;
          end else if (ptr == 4'd15) begin
            // Last entry also missed. End the search here; ptr does not wrap.
            hit   <= 1'b0;
            index <= 4'd0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr <= ptr + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SEARCH) || (state == DONE);

endmodule

// File: doc/target_encoder.md
TARGET_ENCODER -- requirements
Module: target_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: port CLK clocks all state; port Reset_n asynchronously resets all state when low.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  search request, sampled only in IDLE.
REQ-005 req_target  input  16  branch target value to encode, captured with an accepted req.
REQ-006 busy  output  1  high in SEARCH and DONE.
REQ-007 done  output  1  registered one-cycle pulse marking search completion.
REQ-008 hit  output  1  last search found the target.
REQ-009 index  output  4  table index of the match; 0 on miss.
REQ-010 wr_en  input  1  table write strobe; only with TGT_ENC_WRITE_EN.
REQ-011 wr_addr  input  4  table write index.
REQ-012 wr_data  input  16  table write value.

Function
REQ-013 The table SHALL hold 16 entries of 16 bits; the default contents for indices 0..15 are 0, 1, 4, 61, 62, 63, 32, 64, 255, 51, 59, 41, 22, 0, 0, 0.
REQ-014 The FSM SHALL have the states IDLE, SEARCH and DONE; no other encodings reachable.
REQ-015 IDLE: req=1 at an edge latches req_target, clears pointer to 0, moves to SEARCH; req=0 stays IDLE.
REQ-016 SEARCH: each edge compares table[ptr] with the latched target; a match registers hit=1, index=ptr and moves to DONE; a mismatch with ptr<15 increments ptr.
REQ-017 SEARCH miss at ptr=15 SHALL register hit=0, index=0 and move to DONE; ptr does not wrap back into the search.
REQ-018 The scan SHALL be ascending, so the lowest matching index wins; target 0 returns index 0, never 13-15.
REQ-019 Latency: a match at index k SHALL raise done k+1 cycles after the accepting edge; a miss raises done 16 cycles after it.
REQ-020 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-021 req while busy=1 SHALL be ignored and not queued; the next request is accepted at the earliest on the first edge in IDLE.
REQ-022 hit and index SHALL hold their values from DONE until the next completed search or reset.
REQ-023 Changes on req_target after acceptance SHALL NOT affect the running search.
REQ-024 A write and a comparison to the same entry on the same edge SHALL compare the pre-write value; the written value is visible from the next edge.

Reset
REQ-025 Reset_n low SHALL immediately force state=IDLE, ptr=0, busy=0, done=0, hit=0, index=0, latched target=0, and the table to its default contents.
REQ-026 Reset during SEARCH or DONE SHALL abort the search with no done pulse; after release the block is IDLE and accepts req on the first edge.

Configuration
REQ-027 Macro TGT_ENC_WRITE_EN defined: the table is registers written at any state by wr_en/wr_addr/wr_data on the edge, defaults restored on reset.
REQ-028 TGT_ENC_WRITE_EN undefined: the table is constant default contents, wr_en/wr_addr/wr_data are ignored, and search timing is unchanged.

Verification
REQ-029 Reset, req with req_target=61 -> done pulses 4 cycles after accept, hit=1, index=3, busy low the cycle after done.
REQ-030 req_target=100 -> done after 16 cycles, hit=0, index=0; req_target=0 -> done after 1 cycle, index=0.
REQ-031 req held high throughout a search for 22 -> exactly one done (index=12), then the next search is accepted on the first IDLE edge.
REQ-032 With TGT_ENC_WRITE_EN: write 1234 to index 5, search 1234 -> index=5 hit=1; write 99 to index 7 on the edge comparing index 7 during a search for 99 -> old value compared, search continues to a miss; without macro, the same writes are ignored and the 1234 search misses.
REQ-033 Reset_n pulsed low mid-search for 255 -> no done, outputs zero, table defaults; a new search for 255 -> index=8 after 9 cycles.
